// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the data width, the NOP encoding and the buffered fetch entry layout.
package if_fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response channel plus IF/ID handshake.
// The master side is the fetch stage; the slave side is memory plus decode.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_id_valid;
  logic            if_id_ready;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_instr;

  modport master (
    output imem_req_valid, imem_addr, if_id_valid, if_id_pc, if_id_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_id_valid, if_id_pc, if_id_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_id_ready
  );

endinterface

// File: rtl/if_fetch_stage_fetch_queue.sv
// In-order circular queue of fetch entries with allocate, fill, pop and flush.
// Unfilled entries always sit contiguously just behind the tail.
module if_fetch_stage_fetch_queue
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_alloc,
  input  logic [XLEN-1:0]            i_alloc_pc,
  input  logic                       i_fill,
  input  logic [XLEN-1:0]            i_fill_instr,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_occ,
  output logic [$clog2(DEPTH+1)-1:0] o_pend
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_occ;
  logic [CNT_W-1:0] r_pend;
  logic [PTR_W-1:0] w_fill_idx;

  // Oldest unfilled entry; when all DEPTH entries are pending this wraps to the head.
  assign w_fill_idx = r_tail - r_pend[PTR_W-1:0];

  assign o_head = r_mem[r_head];
  assign o_occ  = r_occ;
  assign o_pend = r_pend;

  // NOTE: the entry array is reset too, so the head reads as zero right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_pend <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head <= r_tail;
      r_occ  <= '0;
      r_pend <= '0;
    end else begin
      if (i_alloc) begin
        r_mem[r_tail] <= '{pc: i_alloc_pc, instr: NOP, filled: 1'b0};
        r_tail        <= r_tail + 1'b1;
      end
      if (i_fill) begin
        r_mem[w_fill_idx].instr  <= i_fill_instr;
        r_mem[w_fill_idx].filled <= 1'b1;
      end
      if (i_pop) r_head <= r_head + 1'b1;
      r_occ  <= r_occ + CNT_W'(i_alloc) - CNT_W'(i_pop);
      r_pend <= r_pend + CNT_W'(i_alloc) - CNT_W'(i_fill);
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: issues in-order imem reads at the current PC, holds the PC until
// a request is accepted, and drops wrong-path responses after a redirect.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   pc,
  input  logic              redirect,
  output logic              pc_hold,
  if_fetch_stage_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     w_head;
  logic [CNT_W-1:0] w_occ;
  logic [CNT_W-1:0] w_pend;
  logic [CNT_W-1:0] r_discard;
  logic [CNT_W-1:0] w_discard_next;
  logic [CNT_W-1:0] w_owed;
  logic [CNT_W:0]   w_inflight;
  logic             w_req_valid;
  logic             w_fire;
  logic             w_fill;
  logic             w_if_valid;
  logic             w_pop;

  // Wrong-path responses still owed count against capacity as well.
  assign w_inflight  = {1'b0, w_occ} + {1'b0, r_discard};
  assign w_req_valid = !reset && !redirect && (w_inflight < (CNT_W+1)'(DEPTH));
  assign w_fire      = w_req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = pc;
  assign pc_hold            = reset || (!w_fire && !redirect);

  assign w_fill     = bus.imem_rsp_valid && !redirect && (r_discard == '0) && (w_pend != '0);
  assign w_if_valid = !redirect && (w_occ != '0) && w_head.filled;
  assign w_pop      = w_if_valid && bus.if_id_ready;

  assign bus.if_id_valid = w_if_valid;
  assign bus.if_id_pc    = w_head.pc;
  assign bus.if_id_instr = w_head.instr;

  assign w_owed = r_discard + w_pend;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_discard_next = r_discard;
    if (redirect) begin
      w_discard_next = (bus.imem_rsp_valid && (w_owed != '0)) ? w_owed - 1'b1 : w_owed;
    end else if (bus.imem_rsp_valid && (r_discard != '0)) begin
      w_discard_next = r_discard - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_discard <= '0;
    else       r_discard <= w_discard_next;
  end

  if_fetch_stage_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .i_alloc      (w_fire),
    .i_alloc_pc   (pc),
    .i_fill       (w_fill),
    .i_fill_instr (bus.imem_rsp_data),
    .i_pop        (w_pop),
    .i_flush      (redirect),
    .o_head       (w_head),
    .o_occ        (w_occ),
    .o_pend       (w_pend)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage against a queue-based transaction model
// of the fetch stage, an in-order latency memory and a simple PC register.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic            redirect = 1'b0;
  logic            pc_hold;

  if_fetch_stage_if bus ();

  if_fetch_stage #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .redirect (redirect),
    .pc_hold  (pc_hold),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state: live (right-path) fetches in order, how many of them have
  // returned, and how many wrong-path responses memory still owes.
  logic [31:0] live_q[$];
  int          live_resp = 0;
  int          stale = 0;
  logic [31:0] pc_model = '0;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          cycle = 0;
  int          last_due = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h0001_9E37) ^ 32'h0000_0013;
  endfunction

  task automatic clear_model();
    live_q.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
    live_resp = 0;
    stale     = 0;
    pc_model  = '0;
    last_due  = cycle;
  endtask

  task automatic step(input int p_ready, input int p_dready, input int p_redir,
                      input int max_lat, input bit stray);
    bit          rsp_mem;
    bit          rsp_any;
    bit          exp_req;
    bit          exp_ifv;
    bit          fire;
    bit          pop;
    int          owed;
    int          due;
    logic [31:0] tgt;

    @(posedge clk);
    #1;
    cycle++;
    pc                 = pc_model;
    redirect           = ($urandom_range(0, 99) < p_redir);
    tgt                = 32'($urandom_range(1, 255)) << 4;
    bus.imem_req_ready = ($urandom_range(0, 99) < p_ready);
    bus.if_id_ready    = ($urandom_range(0, 99) < p_dready);
    rsp_mem            = (mem_due_q.size() > 0) && (mem_due_q[0] <= cycle);
    rsp_any            = rsp_mem || stray;
    bus.imem_rsp_valid = rsp_any;
    bus.imem_rsp_data  = rsp_mem ? instr_of(mem_addr_q[0]) : $urandom;
    #1;

    exp_req = !redirect && (live_q.size() + stale < DEPTH);
    check("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
    if (exp_req) check("imem_addr", bus.imem_addr, pc_model);
    fire = exp_req && bus.imem_req_ready;
    check("pc_hold", 32'(pc_hold), 32'(!fire && !redirect));
    exp_ifv = !redirect && (live_q.size() > 0) && (live_resp > 0);
    check("if_id_valid", 32'(bus.if_id_valid), 32'(exp_ifv));
    if (exp_ifv) begin
      check("if_id_pc", bus.if_id_pc, live_q[0]);
      check("if_id_instr", bus.if_id_instr, instr_of(live_q[0]));
    end
    pop = exp_ifv && bus.if_id_ready;

    // Memory: in-order, at least one cycle after accept.
    if (rsp_mem) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      due = cycle + $urandom_range(1, max_lat);
      if (due <= last_due) due = last_due + 1;
      mem_addr_q.push_back(bus.imem_addr);
      mem_due_q.push_back(due);
      last_due = due;
    end

    if (redirect) begin
      owed = stale + (live_q.size() - live_resp);
      if (rsp_any && owed > 0) owed--;
      stale = owed;
      live_q.delete();
      live_resp = 0;
      pc_model  = tgt;
    end else begin
      if (pop) begin
        void'(live_q.pop_front());
        live_resp--;
      end
      if (rsp_any) begin
        if (stale > 0) stale--;
        else if (live_resp < live_q.size()) live_resp++;
      end
      if (fire) begin
        live_q.push_back(pc_model);
        pc_model = pc_model + 32'd4;
      end
    end
  endtask

  task automatic run(input int n, input int p_ready, input int p_dready,
                     input int p_redir, input int max_lat);
    for (int i = 0; i < n; i++) step(p_ready, p_dready, p_redir, max_lat, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst if_id_valid", 32'(bus.if_id_valid), 32'd0);
    check("rst if_id_pc", bus.if_id_pc, 32'd0);
    check("rst if_id_instr", bus.if_id_instr, 32'd0);
    check("rst imem_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst pc_hold", 32'(pc_hold), 32'd1);
  endtask

  // Reset asserted mid-cycle, held over an edge, released before the next edge
  // with the memory not ready so no unmodelled request can be accepted.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset              = 1'b1;
    redirect           = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.if_id_ready    = 1'b1;
    pc                 = '0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    check_reset_outputs();
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-rst imem_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("post-rst pc_hold", 32'(pc_hold), 32'd1);
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.if_id_ready    = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    clear_model();
    apply_reset();

    // Streaming: 1-cycle memory, decode always ready.
    run(12, 100, 100, 0, 1);
    // Decode stall fills the queue, then drains.
    run(6, 100, 0, 0, 1);
    run(6, 100, 100, 0, 1);
    // Memory not ready for 3 cycles.
    run(3, 0, 100, 0, 1);
    run(4, 100, 100, 0, 1);
    // Redirect with fetches in flight, then a redirect during a stall.
    step(100, 100, 0, 3, 1'b0);
    step(100, 100, 0, 3, 1'b0);
    step(100, 100, 100, 3, 1'b0);
    run(6, 100, 0, 0, 2);
    step(100, 0, 100, 2, 1'b0);
    run(8, 100, 100, 0, 2);

    // Mid-operation reset with traffic outstanding, then a stray late response.
    run(3, 100, 0, 0, 3);
    apply_reset();
    step(100, 100, 0, 1, 1'b1);
    run(6, 100, 100, 0, 1);

    // Mixed random traffic.
    run(3000, 70, 70, 8, 4);
    apply_reset();
    run(1000, 90, 50, 3, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
